crc_stream_engine: RTL and testbench

CRC_STREAM_ENGINE -- requirements
Module: crc_stream_engine

---
 rtl/crc_stream_engine_if.sv | 35 +++
 rtl/crc_stream_engine.sv | 170 +++++++++++++++++
 tb/tb_crc_stream_engine.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/crc_stream_engine_if.sv
// Stream/config bundle for crc_stream_engine.
// master: the side that configures the engine and feeds bytes.
// slave: the engine itself.
interface crc_stream_engine_if #(
  parameter int unsigned MAX_WIDTH = 64
);
  localparam int unsigned WB = $clog2(MAX_WIDTH);

  logic                 cfg_load;
  logic [WB-1:0]        cfg_width;
  logic [MAX_WIDTH-1:0] cfg_poly;
  logic [MAX_WIDTH-1:0] cfg_init;
  logic [MAX_WIDTH-1:0] cfg_xorout;
  logic                 cfg_refin;
  logic                 cfg_refout;
  logic                 start;
  logic                 in_valid;
  logic [7:0]           in_data;
  logic                 in_last;
  logic                 in_ready;
  logic                 crc_valid;
  logic [MAX_WIDTH-1:0] crc;

  modport master (
    output cfg_load, cfg_width, cfg_poly, cfg_init, cfg_xorout, cfg_refin, cfg_refout,
    output start, in_valid, in_data, in_last,
    input  in_ready, crc_valid, crc
  );

  modport slave (
    input  cfg_load, cfg_width, cfg_poly, cfg_init, cfg_xorout, cfg_refin, cfg_refout,
    input  start, in_valid, in_data, in_last,
    output in_ready, crc_valid, crc
  );
endinterface

// File: rtl/crc_stream_engine.sv
// Configurable-width CRC engine fed by a byte stream.
// Default build shifts one bit per clock (8 clocks per byte).
// Define CRC_BYTE_PARALLEL_EN to fold a whole byte per handshake instead; results are identical.
module crc_stream_engine #(
  parameter int unsigned MAX_WIDTH = 64
) (
  input logic                clk,
  input logic                rst,
  crc_stream_engine_if.slave bus
);
  localparam int unsigned WB = $clog2(MAX_WIDTH);

  typedef logic [MAX_WIDTH-1:0] crc_t;
  typedef logic [WB-1:0]        width_t;
  typedef enum logic [1:0] {StIdle, StRun, StShift, StDone} state_e;

  // Power-on configuration is CRC-32 (reflected, init/xorout all ones).
  localparam width_t DefWidth = width_t'(31);
  localparam crc_t   DefPoly  = crc_t'(32'h04C1_1DB7);
  localparam crc_t   DefOnes  = crc_t'(32'hFFFF_FFFF);

  state_e state_q;
  logic   in_ready_q;
  logic   crc_valid_q;
  crc_t   crc_q;
  width_t width_q;
  crc_t   poly_q;
  crc_t   init_q;
  crc_t   xorout_q;
  logic   refin_q;
  logic   refout_q;

`ifndef CRC_BYTE_PARALLEL_EN
  logic [2:0] cnt_q;
  logic [7:0] byte_q;
  logic       last_q;
`endif

  crc_t mask;
  crc_t crc_rev;

  // Ones in bit positions 0..w (w is width minus one).
  function automatic crc_t width_mask(input width_t w);
    crc_t m;
    for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
      m[i] = (i <= 32'(w));
    end
    return m;
  endfunction

  // One LFSR step, MSB-first division by x^(w+1) + p.
  function automatic crc_t bit_step(input crc_t r, input logic d, input width_t w,
                                    input crc_t p);
    logic fb;
    fb = r[w] ^ d;
    return ((r << 1) ^ (fb ? p : '0)) & width_mask(w);
  endfunction

`ifdef CRC_BYTE_PARALLEL_EN
  // Eight chained bit steps, ordered by input reflection.
  function automatic crc_t byte_step(input crc_t r, input logic [7:0] data, input logic refin,
                                     input width_t w, input crc_t p);
    crc_t acc;
    acc = r;
    for (int i = 0; i < 8; i++) begin
      acc = bit_step(acc, refin ? data[3'(i)] : data[3'(7 - i)], w, p);
    end
    return acc;
  endfunction

  crc_t crc_byte;
  assign crc_byte = byte_step(crc_q, bus.in_data, refin_q, width_q, poly_q);
`endif

  assign mask = width_mask(width_q);

  // Bit-reverse the live register within the configured width.
  always_comb begin
    width_t idx;
    crc_rev = '0;
    for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
      idx = width_q - width_t'(i);
      if (i <= 32'(width_q)) crc_rev[i] = crc_q[idx];
    end
  end

  assign bus.crc       = ((refout_q ? crc_rev : crc_q) ^ xorout_q) & mask;
  assign bus.in_ready  = in_ready_q;
  assign bus.crc_valid = crc_valid_q;

  // Control FSM, configuration store and CRC register; priority rst > cfg_load > start > data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b0;
      crc_valid_q <= 1'b0;
      crc_q       <= DefOnes;
      width_q     <= DefWidth;
      poly_q      <= DefPoly;
      init_q      <= DefOnes;
      xorout_q    <= DefOnes;
      refin_q     <= 1'b1;
      refout_q    <= 1'b1;
`ifndef CRC_BYTE_PARALLEL_EN
      cnt_q       <= '0;
      byte_q      <= '0;
      last_q      <= 1'b0;
`endif
    end else if (bus.cfg_load) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b0;
      crc_valid_q <= 1'b0;
      crc_q       <= bus.cfg_init & width_mask(bus.cfg_width);
      width_q     <= bus.cfg_width;
      poly_q      <= bus.cfg_poly;
      init_q      <= bus.cfg_init;
      xorout_q    <= bus.cfg_xorout;
      refin_q     <= bus.cfg_refin;
      refout_q    <= bus.cfg_refout;
`ifndef CRC_BYTE_PARALLEL_EN
      cnt_q       <= '0;
`endif
    end else if (bus.start) begin
      state_q     <= StRun;
      in_ready_q  <= 1'b1;
      crc_valid_q <= 1'b0;
      crc_q       <= init_q & mask;
`ifndef CRC_BYTE_PARALLEL_EN
      cnt_q       <= '0;
`endif
    end else begin
      unique case (state_q)
        StRun: begin
          if (bus.in_valid && in_ready_q) begin
`ifdef CRC_BYTE_PARALLEL_EN
            crc_q <= crc_byte;
            if (bus.in_last) begin
              state_q     <= StDone;
              in_ready_q  <= 1'b0;
              crc_valid_q <= 1'b1;
            end
`else
            byte_q     <= bus.in_data;
            last_q     <= bus.in_last;
            cnt_q      <= '0;
            state_q    <= StShift;
            in_ready_q <= 1'b0;
`endif
          end
        end
`ifndef CRC_BYTE_PARALLEL_EN
        StShift: begin
          crc_q <= bit_step(crc_q, byte_q[refin_q ? cnt_q : 3'd7 - cnt_q], width_q, poly_q);
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            if (last_q) begin
              state_q     <= StDone;
              crc_valid_q <= 1'b1;
            end else begin
              state_q    <= StRun;
              in_ready_q <= 1'b1;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_crc_stream_engine.sv
// Scoreboard bench for crc_stream_engine: stimulus pushes expected results,
// a monitor pops and compares on every rising crc_valid.
module tb_crc_stream_engine;
  localparam int MW = 64;
  localparam int WB = 6;

  typedef logic [7:0] bytes_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;

  crc_stream_engine_if #(.MAX_WIDTH(MW)) bus ();

  crc_stream_engine #(.MAX_WIDTH(MW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];
  logic        valid_seen = 1'b0;

  // Reference configuration mirrored by the bench.
  int          m_w;
  logic [63:0] m_poly, m_init, m_xor;
  bit          m_refin, m_refout;

  function automatic logic [63:0] mask_of(input int w);
    return (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  // CRC as a remainder: (init*x^L + msg*x^w) mod (x^w + poly), over a coefficient array.
  function automatic logic [63:0] ref_crc(input bytes_t msg);
    bit          coef [0:1023];
    int          len;
    bit          v;
    logic [63:0] r, rr;
    len = msg.size() * 8;
    for (int k = 0; k < 1024; k++) coef[k] = 1'b0;
    for (int j = 0; j < msg.size(); j++) begin
      for (int b = 0; b < 8; b++) begin
        v = m_refin ? msg[j][b] : msg[j][7-b];
        coef[len - 1 - (j * 8 + b) + m_w] ^= v;
      end
    end
    for (int i = 0; i < m_w; i++) coef[i + len] ^= m_init[i];
    for (int k = len + m_w - 1; k >= m_w; k--) begin
      if (coef[k]) begin
        coef[k] = 1'b0;
        for (int i = 0; i < m_w; i++) coef[k - m_w + i] ^= m_poly[i];
      end
    end
    r = '0;
    for (int i = 0; i < m_w; i++) r[i] = coef[i];
    if (m_refout) begin
      rr = '0;
      for (int i = 0; i < m_w; i++) rr[i] = r[m_w - 1 - i];
      r = rr;
    end
    return (r ^ m_xor) & mask_of(m_w);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: one comparison per result presentation.
  always begin
    logic [63:0] e;
    @(posedge clk);
    #1;
    if (bus.crc_valid === 1'b1 && !valid_seen) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: got %h, required no result", bus.crc);
      end else begin
        e = exp_q.pop_front();
        if (bus.crc !== e) begin
          n_fail++;
          $display("FAIL crc_result: got %h, required %h", bus.crc, e);
        end
      end
    end
    valid_seen = (bus.crc_valid === 1'b1);
  end

  task automatic set_defaults();
    m_w = 32; m_poly = 64'h04C1_1DB7; m_init = 64'hFFFF_FFFF; m_xor = 64'hFFFF_FFFF;
    m_refin = 1'b1; m_refout = 1'b1;
  endtask

  task automatic configure(input int w, input logic [63:0] poly, input logic [63:0] init,
                           input logic [63:0] xorout, input bit refin, input bit refout);
    bytes_t empty;
    m_w = w; m_poly = poly & mask_of(w); m_init = init & mask_of(w);
    m_xor = xorout & mask_of(w); m_refin = refin; m_refout = refout;
    bus.cfg_width  = WB'(w - 1);
    bus.cfg_poly   = poly;
    bus.cfg_init   = init;
    bus.cfg_xorout = xorout;
    bus.cfg_refin  = refin;
    bus.cfg_refout = refout;
    bus.cfg_load   = 1'b1;
    bus.start      = 1'b1;   // cfg_load must win
    @(negedge clk);
    bus.cfg_load = 1'b0;
    bus.start    = 1'b0;
    check("cfg_over_start_idle", {63'd0, bus.in_ready}, 64'd0);
    // Junk on unlatched cfg inputs and on in_valid must be ignored in IDLE.
    bus.cfg_width  = WB'($urandom);
    bus.cfg_poly   = {$urandom, $urandom};
    bus.cfg_init   = {$urandom, $urandom};
    bus.cfg_xorout = {$urandom, $urandom};
    bus.cfg_refin  = 1'($urandom);
    bus.cfg_refout = 1'($urandom);
    bus.in_valid   = 1'b1;
    bus.in_last    = 1'b1;
    bus.in_data    = 8'($urandom);
    repeat (2) @(negedge clk);
    check("idle_ignores_valid", {62'd0, bus.in_ready, bus.crc_valid}, 64'd0);
    check("cfg_load_crc", bus.crc, ref_crc(empty));
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL in_ready_timeout: got 0, required 1");
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (bus.crc_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.crc_valid !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL crc_valid_timeout: got 0, required 1");
    end
  endtask

  task automatic send_bytes(input bytes_t msg, input bit gaps, input bit mark_last);
    for (int j = 0; j < msg.size(); j++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = msg[j];
      bus.in_last  = mark_last && (j == msg.size() - 1);
      wait_ready();
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic run_msg(input bytes_t msg, input logic [63:0] expv, input bit gaps);
    exp_q.push_back(expv);
    pulse_start();
    send_bytes(msg, gaps, 1'b1);
    wait_done();
  endtask

  task automatic timing_test();
    bytes_t m;
    int     n;
    m = '{8'hA5, 8'h3C, 8'h5A};
    exp_q.push_back(ref_crc(m));
    pulse_start();
`ifdef CRC_BYTE_PARALLEL_EN
    for (int j = 0; j < m.size(); j++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = m[j];
      bus.in_last  = (j == m.size() - 1);
      check("par_ready_b2b", {63'd0, bus.in_ready}, 64'd1);
      @(posedge clk);
      #1;
      if (j == m.size() - 1) check("par_valid_on_last", {63'd0, bus.crc_valid}, 64'd1);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
`else
    bus.in_valid = 1'b1;
    bus.in_data  = m[0];
    bus.in_last  = 1'b0;
    check("ser_ready_before", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk);
    #1;
    check("ser_ready_falls", {63'd0, bus.in_ready}, 64'd0);
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("ser_ready_return_edges", 64'(n), 64'd8);
    for (int j = 1; j < m.size(); j++) begin
      @(negedge clk);
      bus.in_data = m[j];
      bus.in_last = (j == m.size() - 1);
      wait_ready();
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    n = 0;
    while (bus.crc_valid !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("ser_valid_edges", 64'(n), 64'd8);
    @(negedge clk);
`endif
  endtask

  initial begin
    bytes_t nine, part, m;
    logic [63:0] poly, par;
    int w;

    bus.cfg_load = 1'b0; bus.cfg_width = '0; bus.cfg_poly = '0; bus.cfg_init = '0;
    bus.cfg_xorout = '0; bus.cfg_refin = 1'b0; bus.cfg_refout = 1'b0;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
    for (int i = 0; i < 9; i++) nine.push_back(8'h31 + 8'(i));
    set_defaults();

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    check("rst_crc_valid", {63'd0, bus.crc_valid}, 64'd0);
    check("rst_crc", bus.crc, 64'd0);

    // Known answers.
    run_msg(nine, 64'h0000_0000_CBF4_3926, 1'b0);
    timing_test();
    configure(16, 64'h1021, 64'hFFFF, 64'h0, 1'b0, 1'b0);
    run_msg(nine, 64'h0000_0000_0000_29B1, 1'b1);
    configure(64, 64'h42F0_E1EB_A9EA_3693, 64'h0, 64'h0, 1'b0, 1'b0);
    run_msg(nine, 64'h6C40_DF5F_0B49_7347, 1'b1);
    configure(8, 64'h07, 64'h0, 64'h0, 1'b0, 1'b0);
    run_msg(nine, 64'h0000_0000_0000_00F4, 1'b0);

    // Width 1 with poly 1 is plain parity of the message.
    configure(1, 64'h1, 64'h0, 64'h0, 1'b0, 1'b0);
    par = '0;
    foreach (nine[i]) par[0] = par[0] ^ (^nine[i]);
    run_msg(nine, par, 1'b0);

    // Randomized configurations and messages against the division model.
    for (int t = 0; t < 20; t++) begin
      w    = $urandom_range(1, 64);
      poly = {$urandom, $urandom};
      configure(w, poly, {$urandom, $urandom}, {$urandom, $urandom},
                1'($urandom), 1'($urandom));
      for (int k = 0; k < 2; k++) begin
        m.delete();
        repeat ($urandom_range(1, 12)) m.push_back(8'($urandom));
        run_msg(m, ref_crc(m), 1'b1);
      end
    end

    // rst mid-message: partial work discarded, CRC-32 defaults back.
    pulse_start();
    part = '{8'h31, 8'h32};
    send_bytes(part, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_defaults();
    check("midrst_crc_valid", {63'd0, bus.crc_valid}, 64'd0);
    check("midrst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    check("midrst_crc", bus.crc, 64'd0);
    run_msg(nine, 64'h0000_0000_CBF4_3926, 1'b0);

    // start mid-message aborts the byte in flight; full resend gives the clean result.
    exp_q.push_back(64'h0000_0000_CBF4_3926);
    pulse_start();
    part = '{8'h31, 8'h32, 8'h33};
    send_bytes(part, 1'b0, 1'b0);
    pulse_start();
    send_bytes(nine, 1'b0, 1'b1);
    wait_done();

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
